// File: rtl/ongoru_pkg.sv
// Shared types for the bimodal predictor: 2-bit counter encoding, in-flight entry, saturating helpers.
// Build option ONGORU_BTB_EN (see iki_bit_ongorucu) does not change anything in this package.
package ongoru_pkg;

    localparam int ONGORU_PC_LEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic [ONGORU_PC_LEN-1:0] pc;
        logic                     tkn;
        logic [ONGORU_PC_LEN-1:0] trg_pc;
    } inflight_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/ongoru_inflight_fifo.sv
// In-flight prediction FIFO: push at tail, pop at head, flush empties it; flush wins over push/pop.
// Unaffected by ONGORU_BTB_EN.
module ongoru_inflight_fifo
    import ongoru_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = inflight_t
) (
    input  logic   clk_i,
    input  logic   rstn_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   flush_i,
    input  entry_t push_data_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q + 1'b1) & PTR_MASK;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q + 1'b1) & PTR_MASK;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/iki_bit_ongorucu.sv
// Bimodal 2-bit branch predictor with in-flight tracking, in-order training and mispredict redirect.
// Define ONGORU_BTB_EN to add a tagged direct-mapped BTB; default build predicts pc+4 as target.
module iki_bit_ongorucu
    import ongoru_pkg::*;
#(
    parameter int PC_LEN         = ONGORU_PC_LEN,
    parameter int TBL_IDX_LEN    = 6,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              fetch_valid_i,
    input  logic [PC_LEN-1:0] fetch_pc_i,
    output logic              fetch_ready_o,
    output logic              pred_valid_o,
    output logic              pred_tkn_o,
    output logic [PC_LEN-1:0] pred_trg_pc_o,
    input  logic              upd_valid_i,
    input  logic [PC_LEN-1:0] upd_pc_i,
    input  logic              upd_tkn_i,
    input  logic [PC_LEN-1:0] upd_trg_pc_i,
    output logic              redirect_valid_o,
    output logic [PC_LEN-1:0] redirect_pc_o,
    output logic              err_o
);
    localparam int TBL_SIZE = 1 << TBL_IDX_LEN;

    ctr_t                   ctr_q [TBL_SIZE];
    ctr_t                   f_ctr;
    inflight_t              head, push_entry;
    logic                   fifo_full, fifo_empty;
    logic                   fetch_acc, upd_acc, mispredict, push;
    logic [TBL_IDX_LEN-1:0] f_idx, u_idx;
    logic [PC_LEN-1:0]      f_seq_pc, u_seq_pc, f_trg;
    logic                   f_tkn;

    logic              pred_valid_d, pred_valid_q;
    logic              pred_tkn_d, pred_tkn_q;
    logic [PC_LEN-1:0] pred_trg_d, pred_trg_q;
    logic              redirect_valid_d, redirect_valid_q;
    logic [PC_LEN-1:0] redirect_pc_d, redirect_pc_q;
    logic              err_d, err_q;

    assign f_idx     = fetch_pc_i[TBL_IDX_LEN+1:2];
    assign u_idx     = upd_pc_i[TBL_IDX_LEN+1:2];
    assign f_ctr     = ctr_q[f_idx];
    assign f_seq_pc  = fetch_pc_i + PC_LEN'(4);
    assign u_seq_pc  = upd_pc_i + PC_LEN'(4);
    assign fetch_ready_o = !fifo_full;
    assign fetch_acc = fetch_valid_i && fetch_ready_o;
    assign upd_acc   = upd_valid_i && !fifo_empty;
    // A fetch coinciding with a mispredict belongs to the wrong path: drop it.
    assign push      = fetch_acc && !mispredict;

`ifdef ONGORU_BTB_EN
    localparam int TAG_W = PC_LEN - TBL_IDX_LEN - 2;

    logic              btb_vld_q [TBL_SIZE];
    logic [TAG_W-1:0]  btb_tag_q [TBL_SIZE];
    logic [PC_LEN-1:0] btb_trg_q [TBL_SIZE];
    logic              btb_hit;

    assign btb_hit    = btb_vld_q[f_idx] &&
                        (btb_tag_q[f_idx] == fetch_pc_i[PC_LEN-1:TBL_IDX_LEN+2]);
    assign f_tkn      = btb_hit && f_ctr[1];
    assign f_trg      = f_tkn ? btb_trg_q[f_idx] : f_seq_pc;
    assign mispredict = upd_acc && ((head.tkn != upd_tkn_i) ||
                                    (upd_tkn_i && (head.trg_pc != upd_trg_pc_i)));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_trg_q[i] <= '0;
            end
        end else if (upd_acc && upd_tkn_i) begin
            btb_vld_q[u_idx] <= 1'b1;
            btb_tag_q[u_idx] <= upd_pc_i[PC_LEN-1:TBL_IDX_LEN+2];
            btb_trg_q[u_idx] <= upd_trg_pc_i;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{fetch_pc_i[1:0]};
`else
    assign f_tkn      = f_ctr[1];
    assign f_trg      = f_seq_pc;
    assign mispredict = upd_acc && (head.tkn != upd_tkn_i);

    logic unused_bits;
    assign unused_bits = ^{fetch_pc_i, head.trg_pc};
`endif

    assign push_entry = '{pc: fetch_pc_i, tkn: f_tkn, trg_pc: f_trg};

    ongoru_inflight_fifo #(
        .DEPTH   (INFLIGHT_DEPTH),
        .entry_t (inflight_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (push),
        .pop_i       (upd_acc),
        .flush_i     (mispredict),
        .push_data_i (push_entry),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        pred_valid_d     = push;
        pred_tkn_d       = pred_tkn_q;
        pred_trg_d       = pred_trg_q;
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        err_d            = err_q;
        if (push) begin
            pred_tkn_d = f_tkn;
            pred_trg_d = f_trg;
        end
        if (mispredict) begin
            redirect_pc_d = upd_tkn_i ? upd_trg_pc_i : u_seq_pc;
        end
        // Out-of-order resolution still trains and pops, but is flagged.
        if ((upd_valid_i && fifo_empty) || (upd_acc && (upd_pc_i != head.pc))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < TBL_SIZE; i++) begin
                ctr_q[i] <= WNT;
            end
            pred_valid_q     <= 1'b0;
            pred_tkn_q       <= 1'b0;
            pred_trg_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            err_q            <= 1'b0;
        end else begin
            if (upd_acc) begin
                ctr_q[u_idx] <= upd_tkn_i ? ctr_inc(ctr_q[u_idx]) : ctr_dec(ctr_q[u_idx]);
            end
            pred_valid_q     <= pred_valid_d;
            pred_tkn_q       <= pred_tkn_d;
            pred_trg_q       <= pred_trg_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            err_q            <= err_d;
        end
    end

    assign pred_valid_o     = pred_valid_q;
    assign pred_tkn_o       = pred_tkn_q;
    assign pred_trg_pc_o    = pred_trg_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_iki_bit_ongorucu.sv
// Directed table-driven bench for iki_bit_ongorucu; expectations follow ONGORU_BTB_EN if defined.
module tb_iki_bit_ongorucu;

`ifdef ONGORU_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif
    localparam logic [31:0] T200 = BTB ? 32'h200 : 32'h104;
    localparam logic [31:0] T500 = BTB ? 32'h500 : 32'h108;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        pred_valid_o;
    logic        pred_tkn_o;
    logic [31:0] pred_trg_pc_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_tkn_i;
    logic [31:0] upd_trg_pc_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    iki_bit_ongorucu dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .fetch_valid_i    (fetch_valid_i),
        .fetch_pc_i       (fetch_pc_i),
        .fetch_ready_o    (fetch_ready_o),
        .pred_valid_o     (pred_valid_o),
        .pred_tkn_o       (pred_tkn_o),
        .pred_trg_pc_o    (pred_trg_pc_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_tkn_i        (upd_tkn_i),
        .upd_trg_pc_i     (upd_trg_pc_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .err_o            (err_o)
    );

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        utkn;
        logic [31:0] utrg;
        logic        e_pv;
        logic        e_tkn;
        logic [31:0] e_trg;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_rdy;
        logic        e_err;
    } vec_t;

    vec_t main_q[$];
    vec_t full_q[$];
    vec_t mism_q[$];

    function automatic vec_t mk(input logic fv, input logic [31:0] fpc,
                                input logic uv, input logic [31:0] upc,
                                input logic utkn, input logic [31:0] utrg,
                                input logic e_pv, input logic e_tkn, input logic [31:0] e_trg,
                                input logic e_rv, input logic [31:0] e_rpc,
                                input logic e_rdy, input logic e_err);
        vec_t v;
        v.fv = fv;   v.fpc = fpc;  v.uv = uv;     v.upc = upc;
        v.utkn = utkn; v.utrg = utrg;
        v.e_pv = e_pv; v.e_tkn = e_tkn; v.e_trg = e_trg;
        v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_rdy = e_rdy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fetch_valid_i = v.fv;
        fetch_pc_i    = v.fpc;
        upd_valid_i   = v.uv;
        upd_pc_i      = v.upc;
        upd_tkn_i     = v.utkn;
        upd_trg_pc_i  = v.utrg;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v);
        @(posedge clk_i);
        #1;
        chk({tag, ".pred_valid"},     32'(pred_valid_o),     32'(v.e_pv));
        chk({tag, ".pred_tkn"},       32'(pred_tkn_o),       32'(v.e_tkn));
        chk({tag, ".pred_trg_pc"},    pred_trg_pc_o,         v.e_trg);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid_o), 32'(v.e_rv));
        chk({tag, ".redirect_pc"},    redirect_pc_o,         v.e_rpc);
        chk({tag, ".fetch_ready"},    32'(fetch_ready_o),    32'(v.e_rdy));
        chk({tag, ".err"},            32'(err_o),            32'(v.e_err));
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rstn_i = 1'b0;
        #1;
        chk({tag, ".pred_valid"},     32'(pred_valid_o),     32'd0);
        chk({tag, ".pred_tkn"},       32'(pred_tkn_o),       32'd0);
        chk({tag, ".pred_trg_pc"},    pred_trg_pc_o,         32'd0);
        chk({tag, ".redirect_valid"}, 32'(redirect_valid_o), 32'd0);
        chk({tag, ".redirect_pc"},    redirect_pc_o,         32'd0);
        chk({tag, ".err"},            32'(err_o),            32'd0);
        chk({tag, ".fetch_ready"},    32'(fetch_ready_o),    32'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    initial begin
        //                  fv fpc       uv upc       t  utrg      pv t trg       rv rpc       rdy err
        main_q.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 0, 32'h000, 0, 32'h000, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 0, 32'h104, 0, 32'h000, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h200, 0, 0, 32'h104, 1, 32'h200, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 1, T200,    0, 32'h200, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h200, 0, 1, T200,    0, 32'h200, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 1, T200,    0, 32'h200, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h200, 0, 1, T200,    0, 32'h200, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 1, T200,    0, 32'h200, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h000, 0, 1, T200,    1, 32'h104, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 1, T200,    0, 32'h104, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h000, 0, 1, T200,    1, 32'h104, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 0, 32'h104, 0, 32'h104, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h000, 0, 0, 32'h104, 0, 32'h104, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 0, 32'h104, 0, 32'h104, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 0, 32'h000, 0, 0, 32'h104, 0, 32'h104, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 0, 32'h104, 0, 32'h104, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h100, 1, 32'h200, 0, 0, 32'h104, 1, 32'h200, 1, 0));
        main_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 0, 32'h104, 0, 32'h200, 1, 0));
        main_q.push_back(mk(1, 32'h104, 1, 32'h100, 0, 32'h000, 1, 0, 32'h108, 0, 32'h200, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h104, 0, 32'h000, 0, 0, 32'h108, 0, 32'h200, 1, 0));
        main_q.push_back(mk(0, 32'h000, 1, 32'h104, 1, 32'h300, 0, 0, 32'h108, 0, 32'h200, 1, 1));
        main_q.push_back(mk(0, 32'h000, 1, 32'h104, 1, 32'h300, 0, 0, 32'h108, 0, 32'h200, 1, 1));
        main_q.push_back(mk(1, 32'h104, 0, 32'h000, 0, 32'h000, 1, 0, 32'h108, 0, 32'h200, 1, 1));

        full_q.push_back(mk(1, 32'h108, 0, 32'h000, 0, 32'h000, 1, 0, 32'h10C, 0, 32'h000, 1, 0));
        full_q.push_back(mk(1, 32'h10C, 0, 32'h000, 0, 32'h000, 1, 0, 32'h110, 0, 32'h000, 1, 0));
        full_q.push_back(mk(1, 32'h110, 0, 32'h000, 0, 32'h000, 1, 0, 32'h114, 0, 32'h000, 1, 0));
        full_q.push_back(mk(1, 32'h114, 0, 32'h000, 0, 32'h000, 1, 0, 32'h118, 0, 32'h000, 0, 0));
        full_q.push_back(mk(1, 32'h118, 0, 32'h000, 0, 32'h000, 0, 0, 32'h118, 0, 32'h000, 0, 0));
        full_q.push_back(mk(1, 32'h118, 1, 32'h108, 0, 32'h000, 0, 0, 32'h118, 0, 32'h000, 1, 0));
        full_q.push_back(mk(1, 32'h118, 1, 32'h10C, 1, 32'h400, 0, 0, 32'h118, 1, 32'h400, 1, 0));
        full_q.push_back(mk(0, 32'h000, 0, 32'h000, 0, 32'h000, 0, 0, 32'h118, 0, 32'h400, 1, 0));
        full_q.push_back(mk(0, 32'h000, 1, 32'h110, 0, 32'h000, 0, 0, 32'h118, 0, 32'h400, 1, 1));
        full_q.push_back(mk(1, 32'h104, 0, 32'h000, 0, 32'h000, 1, 0, 32'h108, 0, 32'h400, 1, 1));
        full_q.push_back(mk(0, 32'h000, 1, 32'h104, 1, 32'h500, 0, 0, 32'h108, 1, 32'h500, 1, 1));
        full_q.push_back(mk(1, 32'h104, 0, 32'h000, 0, 32'h000, 1, 1, T500,    0, 32'h500, 1, 1));

        mism_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 0, 32'h104, 0, 32'h000, 1, 0));
        mism_q.push_back(mk(0, 32'h000, 1, 32'h180, 0, 32'h000, 0, 0, 32'h104, 0, 32'h000, 1, 1));
        mism_q.push_back(mk(1, 32'h100, 0, 32'h000, 0, 32'h000, 1, 0, 32'h104, 0, 32'h000, 1, 1));
        mism_q.push_back(mk(1, 32'h104, 0, 32'h000, 0, 32'h000, 1, 0, 32'h108, 0, 32'h000, 1, 1));
        mism_q.push_back(mk(1, 32'h108, 0, 32'h000, 0, 32'h000, 1, 0, 32'h10C, 0, 32'h000, 1, 1));
        mism_q.push_back(mk(1, 32'h10C, 0, 32'h000, 0, 32'h000, 1, 0, 32'h110, 0, 32'h000, 0, 1));

        rstn_i = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < main_q.size(); i++) begin
            apply(main_q[i], $sformatf("main[%0d]", i));
        end

        async_reset("async_rst1");
        for (int i = 0; i < full_q.size(); i++) begin
            apply(full_q[i], $sformatf("full[%0d]", i));
        end

        async_reset("async_rst2");
        for (int i = 0; i < mism_q.size(); i++) begin
            apply(mism_q[i], $sformatf("pcmis[%0d]", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
